// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: fetch/decode/execute/writeback sequencing over a shared ALU and memory.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes trap and raise a sticky illegal_instr flag.
module multicycle_control_fsm #(
  parameter bit HANDSHAKE    = 1'b1,
  parameter bit SUPPORT_JALR = 1'b1,
  parameter bit SUPPORT_LUI  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       pc_update,
  output logic       branch,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal_instr,
  output logic [3:0] state
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC+4 -> PC
  // DECODE   | read registers, oldPC+imm -> ALUOut
  // MEMADR   | rs1+imm -> ALUOut
  // MEMREAD  | read data memory at ALUOut
  // MEMWB    | load data -> rd
  // MEMWRITE | write data memory at ALUOut
  // EXECR    | rs1 op rs2
  // EXECI    | rs1 op imm
  // ALUWB    | ALUOut -> rd
  // BEQ      | compare rs1/rs2, conditional PC write
  // JAL      | target -> PC, oldPC+4 -> ALUOut
  // JALR     | rs1+imm -> PC
  // JALRLINK | oldPC+4 -> ALUOut
  // LUI      | 0+imm -> ALUOut
  // TRAP     | illegal opcode, parked until reset
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRLINK = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  state_t cur;
  state_t dec_next;
  state_t unknown_next;
  logic   rdy;

  assign rdy = HANDSHAKE ? mem_ready : 1'b1;

`ifdef ILLEGAL_TRAP_EN
  assign unknown_next = S_TRAP;
`else
  assign unknown_next = S_FETCH;
`endif

  always_comb begin
    dec_next = unknown_next;
    case (op)
      7'b0000011, 7'b0100011: dec_next = S_MEMADR;
      7'b0110011:             dec_next = S_EXECR;
      7'b0010011:             dec_next = S_EXECI;
      7'b1100011:             dec_next = S_BEQ;
      7'b1101111:             dec_next = S_JAL;
      7'b1100111:             dec_next = SUPPORT_JALR ? S_JALR : unknown_next;
      7'b0110111:             dec_next = SUPPORT_LUI ? S_LUI : unknown_next;
      default:                dec_next = unknown_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:    if (rdy) cur <= S_DECODE;
        S_DECODE:   cur <= dec_next;
        S_MEMADR:   cur <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (rdy) cur <= S_MEMWB;
        S_MEMWB:    cur <= S_FETCH;
        S_MEMWRITE: if (rdy) cur <= S_FETCH;
        S_EXECR:    cur <= S_ALUWB;
        S_EXECI:    cur <= S_ALUWB;
        S_ALUWB:    cur <= S_FETCH;
        S_BEQ:      cur <= S_FETCH;
        S_JAL:      cur <= S_ALUWB;
        S_JALR:     cur <= S_JALRLINK;
        S_JALRLINK: cur <= S_ALUWB;
        S_LUI:      cur <= S_ALUWB;
        S_TRAP:     cur <= S_TRAP;
        default:    cur <= S_FETCH;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (cur == S_DECODE && dec_next == S_TRAP)
      illegal_q <= 1'b1;
  end

  assign illegal_instr = illegal_q & ~rst;
`else
  assign illegal_instr = 1'b0;
`endif

  // Strobes are decoded combinationally so a synchronous reset kills writes in the cycle it rises.
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    if (!rst) begin
      case (cur)
        S_FETCH: begin
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = rdy;
          pc_update  = rdy;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: adr_src = 1'b1;
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          branch    = 1'b1;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_update = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_update  = 1'b1;
        end
        S_JALRLINK: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_LUI: begin
          alu_src_a = 2'b11;
          alu_src_b = 2'b01;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imm_src = 3'b000;
    case (op)
      7'b0100011: imm_src = 3'b001;
      7'b1100011: imm_src = 3'b010;
      7'b1101111: imm_src = 3'b011;
      7'b0110111: imm_src = SUPPORT_LUI ? 3'b100 : 3'b000;
      default:    imm_src = 3'b000;
    endcase
  end

  assign state = rst ? 4'd0 : cur;

endmodule
